multiplicador_mantiza_seq: RTL
==============================

Name: multiplicador_mantiza_seq

Overview:
Iterative, parametrised floating-point mantissa multiplier. It multiplies two stored mantissas that carry an implicit leading 1, normalises the product, and rounds the result. Rounding is either truncation or round-to-nearest-even, selected per operation. It uses a valid/ready handshake on input and output and sits between operand unpacking and the exponent adder of the FP multiply datapath.

Parameters:
NB_MANTIZA, 8, stored mantissa width N without the hidden bit (legal N ≥ 2).

Ports:
clk  input  1  system clock, rising edge.
i_reset  input  1  synchronous, active-high reset.
i_valid  input  1  operands present.
o_ready  output  1  block can accept operands.
i_mantiza_1  input  NB_MANTIZA  operand A fraction (value 1.A).
i_mantiza_2  input  NB_MANTIZA  operand B fraction (value 1.B).
i_redondeo  input  1  0 = truncate, 1 = round-to-nearest-even.
o_valid  output  1  result present.
i_ready  input  1  consumer accepts result.
o_mantiza  output  NB_MANTIZA  normalised, rounded fraction.
o_aviso_exponente  output  1  exponent must be incremented by 1.
o_inexacto  output  1  discarded bits were non-zero.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on i_reset. It wins over every other event, including mid-operation; any in-flight operation is discarded.
- Reset values: state IDLE, o_ready = 1, o_valid = 0, o_mantiza = 0, o_aviso_exponente = 0, o_inexacto = 0, internal accumulator and counter = 0.
- FSM states: IDLE, CALC, NORM, DONE.
- IDLE: o_ready = 1. On i_valid & o_ready:
  - capture {1,A}, {1,B} (N+1 bits each) and i_redondeo;
  - clear the 2N+2-bit accumulator and the counter;
  - go to CALC.
- CALC: o_ready = 0. Shift-add, one multiplier bit per cycle, LSB first. After exactly N+1 cycles go to NORM. Input changes are ignored.
- NORM: one cycle. The product P (2N+2 bits) is in [1,4).
  - P[2N+1] = 1: aviso = 1, frac = P[2N:N+1], guard = P[N], sticky = |P[N-1:0].
  - P[2N+1] = 0: aviso = 0, frac = P[2N-1:N], guard = P[N-1], sticky = |P[N-2:0].
  - inexacto = guard | sticky, independent of mode.
  - Mode 1 rounds up iff guard & (sticky | frac[0]). Mode 0 never rounds.
  - Round-up carry out of frac (only possible when aviso = 0): frac = 0, aviso = 1.
  - Results are registered; go to DONE.
- DONE: o_valid = 1, outputs held stable while i_ready = 0. On i_ready, go to IDLE with o_valid = 0 next cycle. o_ready stays 0 in DONE, so there is no same-cycle accept.
- Latency: o_valid rises N+2 clock edges after the acceptance edge. Minimum issue interval is N+4 cycles.
- Result outputs keep their last value after handshake completion until the next NORM.
- Arithmetic is unsigned and full width; no intermediate truncation before NORM.

Decomposition:
- Package multiplicador_pkg holds:
  - FSM state encoding localparams (IDLE, CALC, NORM, DONE);
  - rounding mode constants RND_TRUNC = 0, RND_RNE = 1.
- Sub-module redondeo_mantiza: purely combinational normalise + round of P. Parameter NB_MANTIZA. Outputs frac, aviso, inexacto. Instantiated once in NORM; unit-testable standalone.
- Top level: FSM, counter, shift-add datapath, output registers.

Test Plan:
1. N=8, A=0x80, B=0x80, mode 0 (1.5×1.5) -> o_mantiza=0x20, aviso=1, inexacto=0; o_valid exactly 10 edges after accept.
2. A=0xFF, B=0xFF, mode 1 -> P=0x3FC01, o_mantiza=0xFE, aviso=1, inexacto=1 (guard 0, no round-up).
3. A=0x80, B=0x01: mode 0 -> 0x81, aviso=0, inexacto=1; mode 1 -> 0x82. Tie-to-even: A=0x80, B=0x03, mode 1 -> 0x84 (not 0x85).
4. Round overflow: A=0x68, B=0x6C (360×364 = 0x1FFE0), mode 1 -> o_mantiza=0x00, aviso=1, inexacto=1; mode 0 -> 0xFF, aviso=0.
5. Backpressure and issue rules: hold i_ready=0 for 5 cycles in DONE -> outputs and o_valid stable, o_ready=0. A second i_valid during CALC is ignored. Back-to-back operations are spaced ≥ 12 cycles.
6. Reset mid-CALC (cycle 4) -> next cycle IDLE, o_ready=1, o_valid=0, all outputs 0; a following operation A=B=0x00 -> 0x00, aviso=0, inexacto=0.

Source files
------------

// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential mantissa multiplier: FSM encoding
// and rounding mode constants.
package multiplicador_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_NORM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    NORM = ST_NORM,
    DONE = ST_DONE
  } estado_t;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

endpackage

// File: rtl/multiplicador_mantiza_seq_redondeo.sv
// Combinational normalise + round of a (2N+2)-bit mantissa product in [1,4).
module redondeo_mantiza
  import multiplicador_pkg::*;
#(
  parameter int NB_MANTIZA = 8
) (
  input  logic [2*NB_MANTIZA+1:0] i_producto,
  input  logic                    i_modo,
  output logic [NB_MANTIZA-1:0]   o_frac,
  output logic                    o_aviso,
  output logic                    o_inexacto
);

  localparam int MSB = 2*NB_MANTIZA+1;

  logic [NB_MANTIZA-1:0] frac_norm_s;
  logic                  aviso_norm_s;
  logic                  guard_s;
  logic                  sticky_s;
  logic                  sube_s;
  logic [NB_MANTIZA:0]   suma_s;

  // Pick the fraction window by the product's top bit, then apply rounding;
  // a carry out of the fraction bumps the exponent and leaves frac at zero.
  always_comb begin
    frac_norm_s  = {NB_MANTIZA{1'b0}};
    aviso_norm_s = 1'b0;
    guard_s      = 1'b0;
    sticky_s     = 1'b0;
    if (i_producto[MSB]) begin
      aviso_norm_s = 1'b1;
      frac_norm_s  = i_producto[2*NB_MANTIZA:NB_MANTIZA+1];
      guard_s      = i_producto[NB_MANTIZA];
      sticky_s     = |i_producto[NB_MANTIZA-1:0];
    end else begin
      aviso_norm_s = 1'b0;
      frac_norm_s  = i_producto[2*NB_MANTIZA-1:NB_MANTIZA];
      guard_s      = i_producto[NB_MANTIZA-1];
      sticky_s     = |i_producto[NB_MANTIZA-2:0];
    end
    sube_s = (i_modo == RND_RNE) & guard_s & (sticky_s | frac_norm_s[0]);
    suma_s = {1'b0, frac_norm_s} + {{NB_MANTIZA{1'b0}}, sube_s};
  end

  assign o_frac     = suma_s[NB_MANTIZA-1:0];
  assign o_aviso    = aviso_norm_s | suma_s[NB_MANTIZA];
  assign o_inexacto = guard_s | sticky_s;

endmodule

// File: rtl/multiplicador_mantiza_seq.sv
// Iterative shift-add mantissa multiplier (hidden bit implied) with
// normalisation, selectable truncate / round-to-nearest-even, and
// valid/ready handshakes on both sides.
module multiplicador_mantiza_seq
  import multiplicador_pkg::*;
#(
  parameter int NB_MANTIZA = 8
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NB_MANTIZA-1:0] i_mantiza_1,
  input  logic [NB_MANTIZA-1:0] i_mantiza_2,
  input  logic                  i_redondeo,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [NB_MANTIZA-1:0] o_mantiza,
  output logic                  o_aviso_exponente,
  output logic                  o_inexacto
);

  localparam int NB_PROD = 2*NB_MANTIZA+2;
  localparam int NB_CNT  = $clog2(NB_MANTIZA+2);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_MANTIZA);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  estado_t               state_r;
  estado_t               state_next_s;
  logic [NB_PROD-1:0]    mcand_r;
  logic [NB_MANTIZA:0]   mplier_r;
  logic [NB_PROD-1:0]    acc_r;
  logic [NB_CNT-1:0]     cnt_r;
  logic                  modo_r;
  logic                  ready_r;
  logic                  valid_r;
  logic [NB_MANTIZA-1:0] mantiza_r;
  logic                  aviso_r;
  logic                  inexacto_r;
  logic [NB_MANTIZA-1:0] frac_s;
  logic                  aviso_s;
  logic                  inexacto_s;

  // State register.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: accept in IDLE, N+1 shift-add cycles, one normalise
  // cycle, then hold the result until the consumer takes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = NORM;
        end else begin
          state_next_s = CALC;
        end
      end
      NORM: begin
        state_next_s = DONE;
      end
      DONE: begin
        if (i_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operand capture and LSB-first shift-add; the multiplicand shifts left
  // so the accumulator always adds an aligned partial product.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      mcand_r  <= {NB_PROD{1'b0}};
      mplier_r <= {(NB_MANTIZA+1){1'b0}};
      acc_r    <= {NB_PROD{1'b0}};
      cnt_r    <= {NB_CNT{1'b0}};
      modo_r   <= RND_TRUNC;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            mcand_r  <= {{(NB_MANTIZA+1){1'b0}}, 1'b1, i_mantiza_1};
            mplier_r <= {1'b1, i_mantiza_2};
            acc_r    <= {NB_PROD{1'b0}};
            cnt_r    <= {NB_CNT{1'b0}};
            modo_r   <= i_redondeo;
          end
        end
        CALC: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= {mcand_r[NB_PROD-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[NB_MANTIZA:1]};
          cnt_r    <= cnt_r + CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  redondeo_mantiza #(
    .NB_MANTIZA (NB_MANTIZA)
  ) u_redondeo (
    .i_producto (acc_r),
    .i_modo     (modo_r),
    .o_frac     (frac_s),
    .o_aviso    (aviso_s),
    .o_inexacto (inexacto_s)
  );

  // Handshake flags follow the upcoming state so they are registered and
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      ready_r <= (state_next_s == IDLE);
      valid_r <= (state_next_s == DONE);
    end
  end

  // Result registers load only in NORM and otherwise keep their last value.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      mantiza_r  <= {NB_MANTIZA{1'b0}};
      aviso_r    <= 1'b0;
      inexacto_r <= 1'b0;
    end else if (state_r == NORM) begin
      mantiza_r  <= frac_s;
      aviso_r    <= aviso_s;
      inexacto_r <= inexacto_s;
    end
  end

  assign o_ready           = ready_r;
  assign o_valid           = valid_r;
  assign o_mantiza         = mantiza_r;
  assign o_aviso_exponente = aviso_r;
  assign o_inexacto        = inexacto_r;

endmodule
